ex_stage: RTL and testbench

//  Execute stage of the 8-register pipelined core: ID/EX pipeline register, operand forwarding
//  mux, ALU (NOP/ADD/LI/JMP), and the EX/WB result register that drives the register-file write port.

---
 rtl/core_pkg.sv | 14 +
 rtl/ex_alu.sv | 35 +++
 rtl/ex_stage.sv | 130 +++++++++++++
 tb/tb_ex_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 8-register pipelined core: opcodes and default widths.
package core_pkg;

  localparam int CORE_DATA_W = 8;
  localparam int CORE_REG_AW = 3;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ADD = 2'b01,
    OP_LI  = 2'b10,
    OP_JMP = 2'b11
  } op_e;

endpackage

// File: rtl/ex_alu.sv
// Execute-stage ALU: pure combinational decode of op into result, write flag and jump flag.
module ex_alu
  import core_pkg::*;
#(
  parameter int DATA_W = CORE_DATA_W
) (
  input  op_e               op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] y_o,
  output logic              writes_o,
  output logic              is_jmp_o
);

  // Result and side flags per opcode; ADD wraps, carry is dropped.
  always_comb begin
    y_o      = '0;
    writes_o = 1'b0;
    is_jmp_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        y_o      = a_i + b_i;
        writes_o = 1'b1;
      end
      OP_LI: begin
        y_o      = imm_i;
        writes_o = 1'b1;
      end
      OP_JMP:  is_jmp_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, WB bypass at capture, EX forwarding, ALU, EX/WB register,
// jump redirect with squash of the wrong-path ID instruction.
// Optional macro EX_PERF_CNT_EN adds retire_cnt / flush_cnt outputs.
module ex_stage
  import core_pkg::*;
#(
  parameter int DATA_W = CORE_DATA_W,
  parameter int REG_AW = CORE_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [1:0]        id_op,
  input  logic [REG_AW-1:0] id_rdst,
  input  logic [REG_AW-1:0] id_rsrc,
  input  logic [DATA_W-1:0] id_rdst_data,
  input  logic [DATA_W-1:0] id_rsrc_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              F_rdst,
  input  logic              F_rsrc,
  output logic [REG_AW-1:0] EX_rdst,
  output logic              jump_taken,
  output logic [DATA_W-1:0] jump_target,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rdst,
  output logic [DATA_W-1:0] wb_data
`ifdef EX_PERF_CNT_EN
  ,
  output logic [15:0]       retire_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  logic              ex_valid_q;
  op_e               ex_op_q;
  logic [REG_AW-1:0] ex_rdst_q;
  logic [DATA_W-1:0] ex_a_q, ex_b_q, ex_imm_q;
  logic              fwd_a_q, fwd_b_q;

  logic              wb_we_q;
  logic [REG_AW-1:0] wb_rdst_q;
  logic [DATA_W-1:0] wb_data_q;

  logic [DATA_W-1:0] op_a, op_b, alu_y;
  logic [DATA_W-1:0] byp_a, byp_b;
  logic              ex_writes, ex_is_jmp, ex_retire;

  // The instruction in WB is not yet in the register file, so ID reads of its target are stale.
  assign byp_a = (wb_we_q && wb_rdst_q == id_rdst) ? wb_data_q : id_rdst_data;
  assign byp_b = (wb_we_q && wb_rdst_q == id_rsrc) ? wb_data_q : id_rsrc_data;

  // The producer one ahead is now in WB; its result overrides whatever was captured.
  assign op_a = fwd_a_q ? wb_data_q : ex_a_q;
  assign op_b = fwd_b_q ? wb_data_q : ex_b_q;

  ex_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i     (ex_op_q),
    .a_i      (op_a),
    .b_i      (op_b),
    .imm_i    (ex_imm_q),
    .y_o      (alu_y),
    .writes_o (ex_writes),
    .is_jmp_o (ex_is_jmp)
  );

  assign ex_retire   = ex_valid_q & ex_writes;
  assign jump_taken  = ex_valid_q & ex_is_jmp;
  assign jump_target = jump_taken ? ex_imm_q : '0;
  assign EX_rdst     = ex_rdst_q;
  assign wb_we       = wb_we_q;
  assign wb_rdst     = wb_rdst_q;
  assign wb_data     = wb_data_q;

  // ID/EX capture; a taken jump turns the wrong-path ID slot into a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= OP_NOP;
      ex_rdst_q  <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
      fwd_a_q    <= 1'b0;
      fwd_b_q    <= 1'b0;
    end else begin
      ex_valid_q <= id_valid & ~jump_taken;
      ex_op_q    <= op_e'(id_op);
      ex_rdst_q  <= id_rdst;
      ex_a_q     <= byp_a;
      ex_b_q     <= byp_b;
      ex_imm_q   <= id_imm;
      // The forwarding unit only compares addresses; only a real writer may forward.
      fwd_a_q    <= ~F_rdst & ex_retire;
      fwd_b_q    <= ~F_rsrc & ex_retire;
    end
  end

  // EX/WB result register; address and data hold across non-writing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_q   <= 1'b0;
      wb_rdst_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_we_q <= ex_retire;
      if (ex_retire) begin
        wb_rdst_q <= ex_rdst_q;
        wb_data_q <= alu_y;
      end
    end
  end

`ifdef EX_PERF_CNT_EN
  logic [15:0] retire_cnt_q, flush_cnt_q;
  assign retire_cnt = retire_cnt_q;
  assign flush_cnt  = flush_cnt_q;

  // Retirements are counted as they sit on the write port; flushes as valid ID slots are squashed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (wb_we_q)               retire_cnt_q <= retire_cnt_q + 16'd1;
      if (jump_taken && id_valid) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios followed by random instruction streams, checked against
// a program-order architectural model plus a modelled register file and forwarding unit.
module tb_ex_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [1:0] id_op;
  logic [2:0] id_rdst, id_rsrc;
  logic [7:0] id_rdst_data, id_rsrc_data, id_imm;
  logic       F_rdst, F_rsrc;
  logic [2:0] EX_rdst;
  logic       jump_taken;
  logic [7:0] jump_target;
  logic       wb_we;
  logic [2:0] wb_rdst;
  logic [7:0] wb_data;
`ifdef EX_PERF_CNT_EN
  logic [15:0] retire_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_op(id_op), .id_rdst(id_rdst), .id_rsrc(id_rsrc),
    .id_rdst_data(id_rdst_data), .id_rsrc_data(id_rsrc_data), .id_imm(id_imm),
    .F_rdst(F_rdst), .F_rsrc(F_rsrc),
    .EX_rdst(EX_rdst), .jump_taken(jump_taken), .jump_target(jump_target),
    .wb_we(wb_we), .wb_rdst(wb_rdst), .wb_data(wb_data)
`ifdef EX_PERF_CNT_EN
    , .retire_cnt(retire_cnt), .flush_cnt(flush_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // rf: physical register file as the core would present it (written from WB).
  // arch: program-order register values, updated the moment an instruction is accepted.
  logic [7:0] rf[8];
  logic [7:0] arch[8];
  // Model of the instruction in EX and of the WB port.
  bit         m_ex_v;
  logic [1:0] m_ex_op;
  logic [2:0] m_ex_rd;
  logic [7:0] m_ex_imm, m_ex_res;
  bit         m_wb_we;
  logic [2:0] m_wb_rd;
  logic [7:0] m_wb_data;
  int         m_retire, m_flush;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit jt;
    jt = m_ex_v && m_ex_op == 2'b11;
    chk("jump_taken", {15'd0, jump_taken}, {15'd0, jt});
    chk("jump_target", {8'd0, jump_target}, jt ? {8'd0, m_ex_imm} : 16'd0);
    chk("wb_we", {15'd0, wb_we}, {15'd0, m_wb_we});
    chk("wb_rdst", {13'd0, wb_rdst}, {13'd0, m_wb_rd});
    chk("wb_data", {8'd0, wb_data}, {8'd0, m_wb_data});
    if (m_ex_v) chk("EX_rdst", {13'd0, EX_rdst}, {13'd0, m_ex_rd});
`ifdef EX_PERF_CNT_EN
    chk("retire_cnt", retire_cnt, m_retire[15:0]);
    chk("flush_cnt", flush_cnt, m_flush[15:0]);
`endif
  endtask

  task automatic clear_model();
    m_ex_v = 0; m_ex_op = 0; m_ex_rd = 0; m_ex_imm = 0; m_ex_res = 0;
    m_wb_we = 0; m_wb_rd = 0; m_wb_data = 0;
    m_retire = 0; m_flush = 0;
    for (int i = 0; i < 8; i++) arch[i] = rf[i];
  endtask

  // One cycle: present an ID instruction (register-file reads and forwarding selects included),
  // clock it, advance the model, then check outputs at the falling edge.
  // spur: assert a forward select even though the EX instruction does not write.
  task automatic step(input bit v, input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [7:0] imm, input bit spur);
    bit ex_w;
    ex_w = m_ex_v && (m_ex_op == 2'b01 || m_ex_op == 2'b10);
    id_valid = v; id_op = op; id_rdst = rd; id_rsrc = rs; id_imm = imm;
    id_rdst_data = rf[rd]; id_rsrc_data = rf[rs];
    F_rdst = !((ex_w && m_ex_rd == rd) || (!ex_w && spur));
    F_rsrc = !((ex_w && m_ex_rd == rs) || (!ex_w && spur));
    @(posedge clk);
    if (m_wb_we) begin rf[m_wb_rd] = m_wb_data; m_retire++; end
    m_wb_we = ex_w;
    if (ex_w) begin m_wb_rd = m_ex_rd; m_wb_data = m_ex_res; end
    if (m_ex_v && m_ex_op == 2'b11) begin
      m_ex_v = 0;
      if (v) m_flush++;
    end else begin
      m_ex_v = v; m_ex_op = op; m_ex_rd = rd; m_ex_imm = imm;
      if (v) begin
        case (op)
          2'b01: begin arch[rd] = arch[rd] + arch[rs]; m_ex_res = arch[rd]; end
          2'b10: begin arch[rd] = imm; m_ex_res = imm; end
          default: ;
        endcase
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic nop();
    step(1'b0, 2'b00, 3'd0, 3'd0, 8'h00, 1'b0);
  endtask

  task automatic rand_step();
    step($urandom_range(0, 9) != 0, 2'($urandom), 3'($urandom), 3'($urandom), 8'($urandom),
         $urandom_range(0, 3) == 0);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_op = 0; id_rdst = 0; id_rsrc = 0;
    id_rdst_data = 0; id_rsrc_data = 0; id_imm = 0; F_rdst = 1; F_rsrc = 1;
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    rf[3] = 8'h01; rf[4] = 8'hFF; rf[5] = 8'h01;
    clear_model();
    repeat (3) @(negedge clk);
    check_outputs();
    chk("rst_EX_rdst", {13'd0, EX_rdst}, 16'd0);
    rst_n = 1'b1;

    // LI r1,5 then ADD r1,r1 with r1 stale at 0: forwarded result doubles.
    step(1, 2'b10, 3'd1, 3'd0, 8'h05, 0);
    step(1, 2'b01, 3'd1, 3'd1, 8'h00, 0);
    chk("t2_wb_li", {8'd0, wb_data}, 16'h05);
    nop();
    chk("t2_wb_add", {8'd0, wb_data}, 16'h0A);
    chk("t2_we", {15'd0, wb_we}, 16'd1);

    // LI r2,7; NOP; ADD r3,r2 with r2 read stale: bypass from WB.
    step(1, 2'b10, 3'd2, 3'd0, 8'h07, 0);
    nop();
    step(1, 2'b01, 3'd3, 3'd2, 8'h00, 0);
    nop();
    chk("t4_wb_add", {8'd0, wb_data}, 16'h08);
    chk("t4_wb_rdst", {13'd0, wb_rdst}, 16'd3);

    // JMP r1 then ADD r1,r2 with spurious forward select: squashed, nothing written.
    step(1, 2'b11, 3'd1, 3'd0, 8'h44, 0);
    step(1, 2'b01, 3'd1, 3'd2, 8'h00, 1);
    chk("t3_we0", {15'd0, wb_we}, 16'd0);
    nop();
    chk("t3_we1", {15'd0, wb_we}, 16'd0);

    // JMP 0x20: redirect visible for exactly one cycle.
    step(1, 2'b11, 3'd0, 3'd0, 8'h20, 0);
    chk("t5_jt", {15'd0, jump_taken}, 16'd1);
    chk("t5_tgt", {8'd0, jump_target}, 16'h20);
    step(1, 2'b01, 3'd4, 3'd5, 8'h00, 0);
    chk("t5_jt_off", {15'd0, jump_taken}, 16'd0);
    chk("t5_tgt_off", {8'd0, jump_target}, 16'd0);
    nop();
    chk("t5_we", {15'd0, wb_we}, 16'd0);

    // ADD r4,r5 = 0xFF+0x01 wraps to 0.
    step(1, 2'b01, 3'd4, 3'd5, 8'h00, 0);
    nop();
    chk("t6_wb", {8'd0, wb_data}, 16'h00);
    chk("t6_we", {15'd0, wb_we}, 16'd1);
    nop();

    for (int n = 0; n < 300; n++) rand_step();

    // Asynchronous reset with an ADD in EX.
    step(1, 2'b01, 3'd6, 3'd7, 8'h00, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_jt", {15'd0, jump_taken}, 16'd0);
    chk("rst_tgt", {8'd0, jump_target}, 16'd0);
    chk("rst_we", {15'd0, wb_we}, 16'd0);
    chk("rst_wrd", {13'd0, wb_rdst}, 16'd0);
    chk("rst_wdat", {8'd0, wb_data}, 16'd0);
    chk("rst_exrd", {13'd0, EX_rdst}, 16'd0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    nop();
    chk("rst_after_we0", {15'd0, wb_we}, 16'd0);
    nop();
    chk("rst_after_we1", {15'd0, wb_we}, 16'd0);

    for (int n = 0; n < 300; n++) rand_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
